// File: rtl/usb3_pipe_rx_descrambler_pkg.sv
// ---------------------------------------------------------------------------
// usb3_pipe_pkg
// Shared constants and helpers for the USB3 PIPE RX descrambler slice.
//   - K_COM / K_SKP   : K-symbol codes recognised on the RX bus
//   - LFSR_SEED/TAPS  : descrambler LFSR seed and Galois feedback mask
//   - RXS_*           : PIPE RxStatus codes
//   - rx_lock_e       : symbol-lock FSM states
//   - usb3_lfsr_byte  : one 8-step LFSR advance, returns {next_state, key}
// ---------------------------------------------------------------------------
package usb3_pipe_pkg;

  localparam logic [7:0]  K_COM      = 8'hBC;   // K28.5
  localparam logic [7:0]  K_SKP      = 8'h3C;   // K28.1
  localparam logic [15:0] LFSR_SEED  = 16'hFFFF;
  // x^16 + x^5 + x^4 + x^3 + 1, Galois form: x^16 folds back onto bits 5,4,3,0
  localparam logic [15:0] LFSR_TAPS  = 16'h0039;

  localparam logic [2:0] RXS_OK       = 3'b000;
  localparam logic [2:0] RXS_SKP_ADD  = 3'b001;
  localparam logic [2:0] RXS_SKP_REM  = 3'b010;
  localparam logic [2:0] RXS_DETECT   = 3'b011;
  localparam logic [2:0] RXS_DEC_ERR  = 3'b100;
  localparam logic [2:0] RXS_EB_OVF   = 3'b101;
  localparam logic [2:0] RXS_EB_UNF   = 3'b110;
  localparam logic [2:0] RXS_DISP_ERR = 3'b111;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } rx_lock_e;

  // Key bit i is the LFSR MSB before step i, which yields the standard
  // PCIe/USB3 key byte order (FF 17 C0 14 ... after a seed).
  function automatic logic [23:0] usb3_lfsr_byte(input logic [15:0] state);
    logic [15:0] s;
    logic [7:0]  key;
    s   = state;
    key = 8'h00;
    for (int i = 0; i < 8; i++) begin
      key[i] = s[15];
      s      = {s[14:0], 1'b0} ^ (s[15] ? LFSR_TAPS : 16'h0000);
    end
    return {s, key};
  endfunction

endpackage

// File: rtl/usb3_pipe_rx_descrambler_if.sv
// ---------------------------------------------------------------------------
// usb3_pipe_rx_descrambler_if
// Bundles the PHY PIPE RX bus (into the descrambler) and the link-side RX
// bus (out of the descrambler).
//   master : drives phy_pipe_rx_data/datak/valid, phy_rx_status, descr_en;
//            observes rx_data/datak/valid/com/skp/locked (and rx_err_cnt)
//   slave  : the descrambler, the reverse directions
// Optional feature macro: USB3_RX_ERR_CNT_EN adds rx_err_cnt[ERR_CNT_W-1:0].
// ---------------------------------------------------------------------------
interface usb3_pipe_rx_descrambler_if #(
  parameter int ERR_CNT_W = 16
);

  logic [15:0] phy_pipe_rx_data;
  logic [1:0]  phy_pipe_rx_datak;
  logic        phy_pipe_rx_valid;
  logic [2:0]  phy_rx_status;
  logic        descr_en;

  logic [15:0] rx_data;
  logic [1:0]  rx_datak;
  logic        rx_valid;
  logic [1:0]  rx_com;
  logic [1:0]  rx_skp;
  logic        rx_locked;

  if (ERR_CNT_W < 1) begin : g_bad_err_cnt_w
    $error("ERR_CNT_W must be at least 1");
  end

`ifdef USB3_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] rx_err_cnt;

  modport master (
    output phy_pipe_rx_data, phy_pipe_rx_datak, phy_pipe_rx_valid,
           phy_rx_status, descr_en,
    input  rx_data, rx_datak, rx_valid, rx_com, rx_skp, rx_locked, rx_err_cnt
  );

  modport slave (
    input  phy_pipe_rx_data, phy_pipe_rx_datak, phy_pipe_rx_valid,
           phy_rx_status, descr_en,
    output rx_data, rx_datak, rx_valid, rx_com, rx_skp, rx_locked, rx_err_cnt
  );
`else
  modport master (
    output phy_pipe_rx_data, phy_pipe_rx_datak, phy_pipe_rx_valid,
           phy_rx_status, descr_en,
    input  rx_data, rx_datak, rx_valid, rx_com, rx_skp, rx_locked
  );

  modport slave (
    input  phy_pipe_rx_data, phy_pipe_rx_datak, phy_pipe_rx_valid,
           phy_rx_status, descr_en,
    output rx_data, rx_datak, rx_valid, rx_com, rx_skp, rx_locked
  );
`endif

endinterface

// File: rtl/usb3_pipe_rx_descrambler_lfsr_step.sv
// ---------------------------------------------------------------------------
// usb3_rx_lfsr_step
// Processes one received symbol against the descrambler LFSR.
//   in_byte/in_k  : symbol and its K flag
//   state         : LFSR state before this symbol
//   descr_en      : 1 = XOR data symbols with the key, 0 = pass raw
//   out_byte      : descrambled (or raw / K) symbol
//   next_state    : LFSR state after this symbol
//   is_com/is_skp : symbol is K28.5 / K28.1
// COM reseeds, SKP freezes the LFSR, every other symbol advances it 8 steps.
// ---------------------------------------------------------------------------
module usb3_rx_lfsr_step
  import usb3_pipe_pkg::*;
(
  input  logic [7:0]  in_byte,
  input  logic        in_k,
  input  logic [15:0] state,
  input  logic        descr_en,
  output logic [7:0]  out_byte,
  output logic [15:0] next_state,
  output logic        is_com,
  output logic        is_skp
);

  logic [23:0] step_s;
  logic        com_s;
  logic        skp_s;

  // Symbol classification and LFSR/key selection for this symbol.
  always_comb begin
    step_s     = usb3_lfsr_byte(state);
    com_s      = in_k && (in_byte == K_COM);
    skp_s      = in_k && (in_byte == K_SKP);
    out_byte   = in_byte;
    next_state = step_s[23:8];
    if (com_s) begin
      next_state = LFSR_SEED;
    end else if (skp_s) begin
      next_state = state;
    end else if (in_k) begin
      next_state = step_s[23:8];
    end else begin
      next_state = step_s[23:8];
      out_byte   = descr_en ? (in_byte ^ step_s[7:0]) : in_byte;
    end
  end

  assign is_com = com_s;
  assign is_skp = skp_s;

endmodule

// File: rtl/usb3_pipe_rx_descrambler.sv
// ---------------------------------------------------------------------------
// usb3_pipe_rx_descrambler
// Link-side consumer of the 2-symbol PIPE RX bus: descrambles data symbols,
// flags COM/SKP per byte and tracks COM-based symbol lock. All outputs are
// registered, one cycle after the input.
//   phy_pipe_pclk : clock, rising edge
//   reset_n       : synchronous active-low reset
//   pipe (slave)  : phy_pipe_rx_* / phy_rx_status / descr_en in,
//                   rx_data/datak/valid/com/skp/locked out
// Parameters: LOCK_COMS (COMs to lock), UNLOCK_ERRS (consecutive error
// cycles to unlock), ERR_CNT_W (error counter width).
// Optional feature macro: USB3_RX_ERR_CNT_EN adds the saturating rx_err_cnt.
// ---------------------------------------------------------------------------
module usb3_pipe_rx_descrambler
  import usb3_pipe_pkg::*;
#(
  parameter int LOCK_COMS   = 2,
  parameter int UNLOCK_ERRS = 4,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                             phy_pipe_pclk,
  input  logic                             reset_n,
  usb3_pipe_rx_descrambler_if.slave        pipe
);

  // Sized so that a counter one short of its threshold plus the largest
  // single-cycle increment still fits without wrapping.
  localparam int COM_CNT_W = $clog2(LOCK_COMS + 3);
  localparam int ERR_RUN_W = $clog2(UNLOCK_ERRS + 2);

  if (ERR_CNT_W < 1) begin : g_bad_err_cnt_w
    $error("ERR_CNT_W must be at least 1");
  end

  logic [15:0]          lfsr_r;
  logic [15:0]          lfsr_mid_s;
  logic [15:0]          lfsr_nxt_s;
  logic [7:0]           byte0_s;
  logic [7:0]           byte1_s;
  logic [1:0]           com_s;
  logic [1:0]           skp_s;
  logic                 err_s;

  rx_lock_e             state_r;
  rx_lock_e             state_nxt_s;
  logic [COM_CNT_W-1:0] com_cnt_r;
  logic [COM_CNT_W-1:0] com_cnt_nxt_s;
  logic [COM_CNT_W-1:0] com_sum_s;
  logic [ERR_RUN_W-1:0] err_run_r;
  logic [ERR_RUN_W-1:0] err_run_nxt_s;
  logic [ERR_RUN_W-1:0] err_inc_s;

  logic [15:0]          rx_data_r;
  logic [1:0]           rx_datak_r;
  logic                 rx_valid_r;
  logic [1:0]           rx_com_r;
  logic [1:0]           rx_skp_r;
  logic                 rx_locked_r;

  // byte0 is earlier in time, so its LFSR result feeds byte1.
  usb3_rx_lfsr_step u_step0 (
    .in_byte    (pipe.phy_pipe_rx_data[7:0]),
    .in_k       (pipe.phy_pipe_rx_datak[0]),
    .state      (lfsr_r),
    .descr_en   (pipe.descr_en),
    .out_byte   (byte0_s),
    .next_state (lfsr_mid_s),
    .is_com     (com_s[0]),
    .is_skp     (skp_s[0])
  );

  usb3_rx_lfsr_step u_step1 (
    .in_byte    (pipe.phy_pipe_rx_data[15:8]),
    .in_k       (pipe.phy_pipe_rx_datak[1]),
    .state      (lfsr_mid_s),
    .descr_en   (pipe.descr_en),
    .out_byte   (byte1_s),
    .next_state (lfsr_nxt_s),
    .is_com     (com_s[1]),
    .is_skp     (skp_s[1])
  );

  // Error cycle decode: only the 1xx RxStatus codes are errors.
  always_comb begin
    err_s = 1'b0;
    if (pipe.phy_pipe_rx_valid) begin
      case (pipe.phy_rx_status)
        RXS_DEC_ERR, RXS_EB_OVF, RXS_EB_UNF, RXS_DISP_ERR: err_s = 1'b1;
        RXS_OK, RXS_SKP_ADD, RXS_SKP_REM, RXS_DETECT:      err_s = 1'b0;
        default:                                           err_s = 1'b0;
      endcase
    end else begin
      err_s = 1'b0;
    end
  end

  // Lock FSM next state; counters hold across invalid cycles.
  always_comb begin
    state_nxt_s   = state_r;
    com_cnt_nxt_s = com_cnt_r;
    err_run_nxt_s = err_run_r;
    com_sum_s     = com_cnt_r + {{(COM_CNT_W-1){1'b0}}, com_s[0]}
                              + {{(COM_CNT_W-1){1'b0}}, com_s[1]};
    err_inc_s     = err_run_r + {{(ERR_RUN_W-1){1'b0}}, 1'b1};
    if (pipe.phy_pipe_rx_valid) begin
      case (state_r)
        HUNT: begin
          // A COM inside an error cycle never counts toward lock.
          if (err_s) begin
            com_cnt_nxt_s = {COM_CNT_W{1'b0}};
          end else if (com_sum_s >= COM_CNT_W'(LOCK_COMS)) begin
            state_nxt_s   = LOCKED;
            com_cnt_nxt_s = {COM_CNT_W{1'b0}};
          end else begin
            com_cnt_nxt_s = com_sum_s;
          end
        end
        LOCKED: begin
          if (!err_s) begin
            err_run_nxt_s = {ERR_RUN_W{1'b0}};
          end else if (err_inc_s >= ERR_RUN_W'(UNLOCK_ERRS)) begin
            state_nxt_s   = HUNT;
            err_run_nxt_s = {ERR_RUN_W{1'b0}};
          end else begin
            err_run_nxt_s = err_inc_s;
          end
        end
        default: begin
          state_nxt_s   = HUNT;
          com_cnt_nxt_s = {COM_CNT_W{1'b0}};
          err_run_nxt_s = {ERR_RUN_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt_s   = state_r;
      com_cnt_nxt_s = com_cnt_r;
      err_run_nxt_s = err_run_r;
    end
  end

  // Lock FSM state and counters.
  always_ff @(posedge phy_pipe_pclk) begin
    if (!reset_n) begin
      state_r   <= HUNT;
      com_cnt_r <= {COM_CNT_W{1'b0}};
      err_run_r <= {ERR_RUN_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      com_cnt_r <= com_cnt_nxt_s;
      err_run_r <= err_run_nxt_s;
    end
  end

  // LFSR and registered link-side outputs; idle cycles zero the data path.
  always_ff @(posedge phy_pipe_pclk) begin
    if (!reset_n) begin
      lfsr_r      <= LFSR_SEED;
      rx_data_r   <= 16'h0000;
      rx_datak_r  <= 2'b00;
      rx_valid_r  <= 1'b0;
      rx_com_r    <= 2'b00;
      rx_skp_r    <= 2'b00;
      rx_locked_r <= 1'b0;
    end else if (pipe.phy_pipe_rx_valid) begin
      lfsr_r      <= lfsr_nxt_s;
      rx_data_r   <= {byte1_s, byte0_s};
      rx_datak_r  <= pipe.phy_pipe_rx_datak;
      rx_valid_r  <= 1'b1;
      rx_com_r    <= com_s;
      rx_skp_r    <= skp_s;
      rx_locked_r <= (state_nxt_s == LOCKED);
    end else begin
      lfsr_r      <= lfsr_r;
      rx_data_r   <= 16'h0000;
      rx_datak_r  <= 2'b00;
      rx_valid_r  <= 1'b0;
      rx_com_r    <= 2'b00;
      rx_skp_r    <= 2'b00;
      rx_locked_r <= (state_nxt_s == LOCKED);
    end
  end

  assign pipe.rx_data   = rx_data_r;
  assign pipe.rx_datak  = rx_datak_r;
  assign pipe.rx_valid  = rx_valid_r;
  assign pipe.rx_com    = rx_com_r;
  assign pipe.rx_skp    = rx_skp_r;
  assign pipe.rx_locked = rx_locked_r;

`ifdef USB3_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Saturating count of error cycles, cleared only by reset.
  always_ff @(posedge phy_pipe_pclk) begin
    if (!reset_n) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (err_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign pipe.rx_err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_usb3_pipe_rx_descrambler.sv
// ---------------------------------------------------------------------------
// tb_usb3_pipe_rx_descrambler
// Directed bench for usb3_pipe_rx_descrambler (LOCK_COMS=2, UNLOCK_ERRS=4,
// ERR_CNT_W=2). Expected values are hand-derived from the LFSR key stream
// FF 17 C0 14 B2 E7 02 82 that follows a COM.
// ---------------------------------------------------------------------------
module tb_usb3_pipe_rx_descrambler;
  import usb3_pipe_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  usb3_pipe_rx_descrambler_if #(.ERR_CNT_W(2)) bus ();

  usb3_pipe_rx_descrambler #(
    .LOCK_COMS   (2),
    .UNLOCK_ERRS (4),
    .ERR_CNT_W   (2)
  ) dut (
    .phy_pipe_pclk (clk),
    .reset_n       (reset_n),
    .pipe          (bus)
  );

  always #5 clk = ~clk;

  // Apply one input cycle, then sample 1 time unit after the capturing edge.
  task automatic drive(input logic rst, input logic [15:0] d, input logic [1:0] k,
                       input logic v, input logic [2:0] st, input logic de);
    reset_n                   = rst;
    bus.phy_pipe_rx_data      = d;
    bus.phy_pipe_rx_datak     = k;
    bus.phy_pipe_rx_valid     = v;
    bus.phy_rx_status         = st;
    bus.descr_en              = de;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] pk(input logic [15:0] d, input logic [1:0] k,
                                     input logic v, input logic [1:0] c,
                                     input logic [1:0] s, input logic l);
    return {d, k, v, c, s, l};
  endfunction

  function automatic logic [23:0] obs();
    return {bus.rx_data, bus.rx_datak, bus.rx_valid, bus.rx_com, bus.rx_skp, bus.rx_locked};
  endfunction

  // Vectors are {data[15:0], datak[1:0], valid, com[1:0], skp[1:0], locked}.
  task automatic chk(input string tag, input logic [23:0] o, input logic [23:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  initial begin
    bus.phy_pipe_rx_data  = 16'h0000;
    bus.phy_pipe_rx_datak = 2'b00;
    bus.phy_pipe_rx_valid = 1'b0;
    bus.phy_rx_status     = 3'b000;
    bus.descr_en          = 1'b0;

    // 1. reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'($urandom), 2'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
      chk("reset_outputs", obs(), pk(16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    end

    // 2. COM then data: first keys FF, then 17 C0, then 14 B2
    drive(1'b1, 16'h00BC, 2'b01, 1'b1, RXS_OK, 1'b1);
    chk("com_first", obs(), pk(16'hFFBC, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0));
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_OK, 1'b1);
    chk("key_17_c0", obs(), pk(16'hC017, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_OK, 1'b1);
    chk("key_14_b2", obs(), pk(16'hB214, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));

    // 3. mid-stream reset, then SKP pair freezes the LFSR
    drive(1'b0, 16'h00BC, 2'b01, 1'b1, RXS_OK, 1'b1);
    chk("reset_mid", obs(), pk(16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    drive(1'b1, 16'h00BC, 2'b01, 1'b1, RXS_OK, 1'b1);
    chk("skp_com", obs(), pk(16'hFFBC, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0));
    drive(1'b1, 16'h3C3C, 2'b11, 1'b1, RXS_OK, 1'b1);
    chk("skp_pair", obs(), pk(16'h3C3C, 2'b11, 1'b1, 2'b00, 2'b11, 1'b0));
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_OK, 1'b1);
    chk("skp_hold", obs(), pk(16'hC017, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));

    // 4. lock FSM
    drive(1'b0, 16'h0000, 2'b00, 1'b0, RXS_OK, 1'b1);
    drive(1'b1, 16'h00BC, 2'b01, 1'b1, RXS_OK, 1'b1);
    chk("lock_com1", obs(), pk(16'hFFBC, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0));
    drive(1'b1, 16'h00BC, 2'b01, 1'b1, RXS_OK, 1'b1);
    chk("lock_com2", obs(), pk(16'hFFBC, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_DEC_ERR, 1'b1);
      chk("err_run_below", 24'(bus.rx_locked), 24'h1);
    end
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_DEC_ERR, 1'b1);
    chk("unlock_4th", 24'(bus.rx_locked), 24'h0);
    drive(1'b1, 16'hBCBC, 2'b11, 1'b1, RXS_OK, 1'b1);
    chk("lock_double_com", obs(), pk(16'hBCBC, 2'b11, 1'b1, 2'b11, 2'b00, 1'b1));
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_EB_OVF, 1'b1);
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_EB_UNF, 1'b1);
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_DISP_ERR, 1'b1);
    chk("err3_locked", 24'(bus.rx_locked), 24'h1);
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_SKP_ADD, 1'b1);
    chk("clean_clears_run", 24'(bus.rx_locked), 24'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_DEC_ERR, 1'b1);
    end
    chk("err3_after_clean", 24'(bus.rx_locked), 24'h1);
    drive(1'b1, 16'h5A5A, 2'b11, 1'b0, RXS_DEC_ERR, 1'b1);
    chk("invalid_hold", obs(), pk(16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1));
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_DEC_ERR, 1'b1);
    chk("unlock_across_gap", 24'(bus.rx_locked), 24'h0);
    drive(1'b1, 16'h00BC, 2'b01, 1'b1, RXS_DEC_ERR, 1'b1);
    chk("err_com_flagged", obs(), pk(16'hFFBC, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0));
    drive(1'b1, 16'h00BC, 2'b01, 1'b1, RXS_OK, 1'b1);
    chk("err_com_not_counted", obs(), pk(16'hFFBC, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0));
    drive(1'b1, 16'h00BC, 2'b01, 1'b1, RXS_OK, 1'b1);
    chk("relock", obs(), pk(16'hFFBC, 2'b01, 1'b1, 2'b01, 2'b00, 1'b1));

    // 5. valid gaps and raw pass-through keep the key sequence
    drive(1'b0, 16'h0000, 2'b00, 1'b0, RXS_OK, 1'b1);
    drive(1'b1, 16'h00BC, 2'b01, 1'b1, RXS_OK, 1'b1);
    chk("gap_com", obs(), pk(16'hFFBC, 2'b01, 1'b1, 2'b01, 2'b00, 1'b0));
    drive(1'b1, 16'hA5A5, 2'b10, 1'b0, RXS_OK, 1'b1);
    chk("gap_idle", obs(), pk(16'h0000, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0));
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_OK, 1'b1);
    chk("gap_key_17_c0", obs(), pk(16'hC017, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));
    drive(1'b1, 16'h1111, 2'b00, 1'b0, RXS_OK, 1'b1);
    drive(1'b1, 16'h2222, 2'b01, 1'b0, RXS_OK, 1'b1);
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_OK, 1'b1);
    chk("gap_key_14_b2", obs(), pk(16'hB214, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));
    drive(1'b1, 16'h1234, 2'b00, 1'b1, RXS_OK, 1'b0);
    chk("raw_pass", obs(), pk(16'h1234, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0));
    drive(1'b1, 16'hFC00, 2'b10, 1'b1, RXS_OK, 1'b1);
    chk("key_after_raw", obs(), pk(16'hFC82, 2'b10, 1'b1, 2'b00, 2'b00, 1'b0));

`ifdef USB3_RX_ERR_CNT_EN
    // 6. saturating error counter
    drive(1'b0, 16'h0000, 2'b00, 1'b0, RXS_OK, 1'b1);
    chk("errcnt_reset", 24'(bus.rx_err_cnt), 24'h0);
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_SKP_ADD, 1'b1);
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_SKP_REM, 1'b1);
    chk("errcnt_skp_status", 24'(bus.rx_err_cnt), 24'h0);
    drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_DEC_ERR, 1'b1);
    chk("errcnt_one", 24'(bus.rx_err_cnt), 24'h1);
    drive(1'b1, 16'h0000, 2'b00, 1'b0, RXS_DISP_ERR, 1'b1);
    chk("errcnt_invalid", 24'(bus.rx_err_cnt), 24'h1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0000, 2'b00, 1'b1, RXS_EB_OVF, 1'b1);
    end
    chk("errcnt_saturate", 24'(bus.rx_err_cnt), 24'h3);
    drive(1'b0, 16'h0000, 2'b00, 1'b1, RXS_DEC_ERR, 1'b1);
    chk("errcnt_cleared", 24'(bus.rx_err_cnt), 24'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
